// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder_if
// Brief    : Request/response bus between a load/store unit and the data memory.
// Revision : 1.0
// ============================================================================
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_func3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_func3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : Local data memory serving RISC-V loads/stores in three-cycle turns.
// Revision : 1.0
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                clk,
    input  logic                reset,
    data_mem_responder_if.slave bus,
    input  logic [31:0]         watch_addr,
    output logic [31:0]         watch_data
);
    localparam int c_AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [31:0]     r_mem [DEPTH_WORDS];
    logic            r_write;
    logic [2:0]      r_func3;
    logic [c_AW+1:0] r_addr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rspRdata;
    logic            r_rspErr;

    logic [c_AW-1:0] w_idx;
    logic [31:0]     w_word;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_loadData;
    logic            w_err;
    logic [3:0]      w_mask;
    logic [31:0]     w_wdataShift;
    logic [31:0]     w_merged;
    logic            w_unused;

    assign w_idx  = r_addr[c_AW+1:2];
    assign w_word = r_mem[w_idx];

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_rdata = r_rspRdata;
    assign bus.rsp_err   = r_rspErr;

    assign watch_data = r_mem[watch_addr[c_AW+1:2]];

    // Address bits above the memory span wrap and are deliberately ignored.
    assign w_unused = &{1'b0, bus.req_addr[31:c_AW+2], watch_addr[31:c_AW+2], watch_addr[1:0]};

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:   if (bus.req_valid) w_nextState = S_ACCESS;
            S_ACCESS: w_nextState = S_RESP;
            S_RESP:   w_nextState = S_IDLE;
            default:  w_nextState = S_IDLE;
        endcase
    end

    // Misalignment and illegal funct3 share one error flag; unsigned forms are load-only.
    always_comb begin
        w_err = 1'b0;
        case (r_func3)
            3'd0:    w_err = 1'b0;
            3'd1:    w_err = r_addr[0];
            3'd2:    w_err = |r_addr[1:0];
            3'd4:    w_err = r_write;
            3'd5:    w_err = r_write | r_addr[0];
            default: w_err = 1'b1;
        endcase
    end

    assign w_byte = w_word[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_loadData = 32'd0;
        case (r_func3)
            3'd0:    w_loadData = {{24{w_byte[7]}}, w_byte};
            3'd1:    w_loadData = {{16{w_half[15]}}, w_half};
            3'd2:    w_loadData = w_word;
            3'd4:    w_loadData = {24'd0, w_byte};
            3'd5:    w_loadData = {16'd0, w_half};
            default: w_loadData = 32'd0;
        endcase
    end

    always_comb begin
        w_mask = 4'b1111;
        case (r_func3[1:0])
            2'd0:    w_mask = 4'b0001 << r_addr[1:0];
            2'd1:    w_mask = 4'b0011 << r_addr[1:0];
            default: w_mask = 4'b1111;
        endcase
    end

    assign w_wdataShift = r_wdata << {r_addr[1:0], 3'b000};

    generate
        for (genvar l = 0; l < 4; l++) begin : g_lane
            assign w_merged[8*l +: 8] = w_mask[l] ? w_wdataShift[8*l +: 8] : w_word[8*l +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_write    <= 1'b0;
            r_func3    <= 3'd0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_rspRdata <= 32'd0;
            r_rspErr   <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else begin
            r_state <= w_nextState;
            if (r_state == S_IDLE && bus.req_valid) begin
                r_write <= bus.req_write;
                r_func3 <= bus.req_func3;
                r_addr  <= bus.req_addr[c_AW+1:0];
                r_wdata <= bus.req_wdata;
            end
            if (r_state == S_ACCESS) begin
                r_rspErr   <= w_err;
                r_rspRdata <= (w_err || r_write) ? 32'd0 : w_loadData;
                if (r_write && !w_err) begin
                    r_mem[w_idx] <= w_merged;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Brief    : Randomized scoreboard bench against a byte-array memory model.
// Revision : 1.0
// ============================================================================
module tb_data_mem_responder;
    localparam int DEPTH  = 256;
    localparam int NBYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] watch_addr = 32'd0;
    logic [31:0] watch_data;

    data_mem_responder_if bus();

    data_mem_responder #(.DEPTH_WORDS(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .watch_addr (watch_addr),
        .watch_data (watch_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } rsp_t;

    byte unsigned mb [NBYTES];
    rsp_t         sb [$];
    int           nChecks = 0;
    int           nFails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic void clearModel();
        for (int i = 0; i < NBYTES; i++) mb[i] = 8'd0;
    endfunction

    function automatic logic [31:0] modelWord(input logic [31:0] a);
        int base;
        logic [31:0] v;
        base = int'(a & 32'(NBYTES - 4));
        v = 32'd0;
        for (int i = 0; i < 4; i++) v |= 32'(mb[base + i]) << (8 * i);
        return v;
    endfunction

    // Applies the access to the byte model and returns the response it must produce.
    function automatic rsp_t model(input bit w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        rsp_t r;
        int sz;
        bit ok;
        int base;
        logic [31:0] v;
        r.rd = 32'd0;
        r.err = 1'b0;
        case (f)
            3'd0, 3'd4: sz = 1;
            3'd1, 3'd5: sz = 2;
            3'd2:       sz = 4;
            default:    sz = 0;
        endcase
        ok = (sz != 0) && (!w || f <= 3'd2);
        if (ok && (int'(a[1:0]) % sz) != 0) ok = 1'b0;
        if (!ok) begin
            r.err = 1'b1;
            return r;
        end
        base = int'(a & 32'(NBYTES - 1));
        if (w) begin
            for (int i = 0; i < sz; i++) mb[base + i] = d[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < sz; i++) v |= 32'(mb[base + i]) << (8 * i);
            if (f < 3'd3 && sz < 4 && v[8*sz-1]) v |= ~((32'd1 << (8 * sz)) - 32'd1);
            r.rd = v;
        end
        return r;
    endfunction

    always @(negedge clk) begin : monitor
        rsp_t e;
        if (!reset && bus.rsp_valid) begin
            if (sb.size() == 0) begin
                nChecks++;
                nFails++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 required no response");
            end else begin
                e = sb.pop_front();
                chk("rsp_rdata", bus.rsp_rdata, e.rd);
                chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
            end
        end
    end

    task automatic issue(input bit w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        int t = 0;
        @(negedge clk);
        bus.req_write = w;
        bus.req_func3 = f;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_valid = 1'b1;
        while (!bus.req_ready && t < 10) begin
            @(negedge clk);
            t++;
        end
        if (!bus.req_ready) begin
            chk("accept_timeout", {31'd0, bus.req_ready}, 32'd1);
        end else begin
            sb.push_back(model(w, f, a, d));
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            chk("rsp_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic chkWatch(input string name, input logic [31:0] a);
        watch_addr = a;
        #1 chk(name, watch_data, modelWord(a));
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_func3 = 3'd0;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        clearModel();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("reset_rdata", bus.rsp_rdata, 32'd0);
        chk("reset_err", {31'd0, bus.rsp_err}, 32'd0);
        chkWatch("reset_watch", 32'h40);

        // Latency: two not-ready cycles, response in the second.
        issue(1'b0, 3'd2, 32'h10, 32'd0);
        @(negedge clk);
        chk("lat_ready1", {31'd0, bus.req_ready}, 32'd0);
        chk("lat_valid1", {31'd0, bus.rsp_valid}, 32'd0);
        @(negedge clk);
        chk("lat_ready2", {31'd0, bus.req_ready}, 32'd0);
        chk("lat_valid2", {31'd0, bus.rsp_valid}, 32'd1);
        @(negedge clk);
        chk("lat_ready3", {31'd0, bus.req_ready}, 32'd1);
        drain();

        issue(1'b1, 3'd2, 32'h40, 32'h87654321);
        issue(1'b0, 3'd0, 32'h43, 32'd0);
        issue(1'b0, 3'd4, 32'h43, 32'd0);
        issue(1'b0, 3'd1, 32'h42, 32'd0);
        issue(1'b0, 3'd5, 32'h40, 32'd0);
        issue(1'b1, 3'd0, 32'h41, 32'h123456AA);
        drain();
        watch_addr = 32'h40;
        #1 chk("sb_watch_const", watch_data, 32'h8765AA21);
        issue(1'b0, 3'd2, 32'h42, 32'd0);
        issue(1'b1, 3'd1, 32'h43, 32'h0000FFFF);
        issue(1'b0, 3'd3, 32'h40, 32'd0);
        issue(1'b1, 3'd4, 32'h44, 32'h11111111);
        drain();
        chkWatch("err_watch_40", 32'h40);
        chkWatch("err_watch_44", 32'h44);

        // Reset while the store is in ACCESS: no write, no response.
        @(negedge clk);
        bus.req_write = 1'b1;
        bus.req_func3 = 3'd2;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'hDEADBEEF;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        clearModel();
        repeat (4) @(negedge clk);
        watch_addr = 32'h20;
        #1 chk("abort_watch_20", watch_data, 32'd0);
        chkWatch("abort_watch_40", 32'h40);

        // Reset overrides a simultaneous request.
        @(negedge clk);
        reset = 1'b1;
        bus.req_write = 1'b0;
        bus.req_func3 = 3'd2;
        bus.req_addr  = 32'h0;
        bus.req_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.req_valid = 1'b0;
        #1 chk("rst_override_ready", {31'd0, bus.req_ready}, 32'd1);
        repeat (3) @(negedge clk);
        chk("rst_override_ready2", {31'd0, bus.req_ready}, 32'd1);

        // Address wrap, then a held request accepted every third cycle.
        issue(1'b1, 3'd2, 32'(NBYTES + 8), 32'h0000CAFE);
        drain();
        watch_addr = 32'h8;
        #1 chk("wrap_watch_const", watch_data, 32'h0000CAFE);
        bus.req_write = 1'b0;
        bus.req_func3 = 3'd2;
        bus.req_addr  = 32'h8;
        bus.req_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            chk("b2b_ready", {31'd0, bus.req_ready}, (k % 3 == 0) ? 32'd1 : 32'd0);
            if (bus.req_ready) sb.push_back(model(1'b0, 3'd2, 32'h8, 32'd0));
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        drain();

        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            logic [2:0]  f;
            bit          w;
            w = 1'($urandom_range(0, 1));
            f = 3'($urandom_range(0, 7));
            a = ($urandom & ~32'h3FF) | 32'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0) begin
                if (f[1:0] == 2'd1) a[0] = 1'b0;
                if (f[1:0] == 2'd2) a[1:0] = 2'd0;
            end
            issue(w, f, a, $urandom);
            if (n % 8 == 7) begin
                drain();
                chkWatch("rand_watch", 32'($urandom_range(0, 127)));
            end
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
`default_nettype wire
